// File: rtl/jtpopeye_dwnld_pkg.sv
// Shared types and constants for the ROM-download router.
//  - dwnld_state_t : router FSM encoding
//  - MASK_*        : active-low SDRAM byte-lane masks
package jtpopeye_dwnld_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SDRAM = 2'd1,
        ST_PROM  = 2'd2,
        ST_FLUSH = 2'd3
    } dwnld_state_t;

    // Active-low lane select: even byte writes the low lane, odd byte the high lane
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

endpackage

// File: rtl/jtpopeye_dwnld_skid.sv
// One-entry skid buffer for loader strobes that arrive while the router is busy.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  push              store push_addr/push_data (accepted if empty or popped this cycle)
//  pop               current entry is consumed this cycle
//  push_addr/data    incoming loader byte
//  valid/addr/data   stored entry
//  overflow          sticky: a push found the entry full and was dropped
module jtpopeye_dwnld_skid
    import jtpopeye_dwnld_pkg::*;
#(
    parameter int unsigned AW = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [AW-1:0]     push_addr,
    input  logic [DATA_W-1:0] push_data,
    output logic              valid,
    output logic [AW-1:0]     addr,
    output logic [DATA_W-1:0] data,
    output logic              overflow
);

    logic              valid_q, valid_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overflow_q, overflow_d;

    // A pop frees the entry in the same cycle, so a simultaneous push refills it
    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        if (push && (!valid_q || pop)) begin
            valid_d = 1'b1;
            addr_d  = push_addr;
            data_d  = push_data;
        end else if (push) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid    = valid_q;
    assign addr     = addr_q;
    assign data     = data_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/jtpopeye_dwnld.sv
// ROM-download router: splits the loader byte stream between SDRAM (masked word
// writes with prog_rdy handshake) and NPROM on-chip PROM slots (one-hot write enables).
// Ports:
//  clk, rst                       clock, synchronous active-high reset
//  downloading, ioctl_*           loader stream; strobes ignored while downloading=0
//  prog_addr/data/mask/we, prog_rdy   SDRAM write port (we held until rdy)
//  prom_addr/data/we              PROM slot write port (we one cycle, one-hot)
//  busy                           item in flight or skid occupied
//  dwnld_done                     one-cycle pulse after download end once fully flushed
//  overflow                       sticky lost-strobe flag
module jtpopeye_dwnld
    import jtpopeye_dwnld_pkg::*;
#(
    parameter int unsigned     AW         = 22,
    parameter logic [AW-1:0]   PROM_START = AW'(22'h0C000),
    parameter int unsigned     NPROM      = 6,
    parameter int unsigned     PROM_AW    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,
    input  logic [AW-1:0]      ioctl_addr,
    input  logic [7:0]         ioctl_data,
    input  logic               ioctl_wr,
    output logic [AW-1:0]      prog_addr,
    output logic [7:0]         prog_data,
    output logic [1:0]         prog_mask,
    output logic               prog_we,
    input  logic               prog_rdy,
    output logic [PROM_AW-1:0] prom_addr,
    output logic [7:0]         prom_data,
    output logic [NPROM-1:0]   prom_we,
    output logic               busy,
    output logic               dwnld_done,
    output logic               overflow
);

    localparam int unsigned IW = AW - PROM_AW;

    dwnld_state_t state_q, state_d;

    logic [AW-1:0]      prog_addr_q, prog_addr_d;
    logic [7:0]         prog_data_q, prog_data_d;
    logic [1:0]         prog_mask_q, prog_mask_d;
    logic               prog_we_q, prog_we_d;
    logic [PROM_AW-1:0] prom_addr_q, prom_addr_d;
    logic [7:0]         prom_data_q, prom_data_d;
    logic [NPROM-1:0]   prom_we_q, prom_we_d;
    logic               busy_q, busy_d;
    logic               dwnld_done_q, dwnld_done_d;
    logic               flush_pend_q, flush_pend_d;
    logic               downloading_q;

    logic               strobe;
    logic               skid_valid, skid_ovf;
    logic [AW-1:0]      skid_addr;
    logic [7:0]         skid_data;
    logic               skid_push, skid_pop, skid_valid_nx;
    logic [AW-1:0]      item_addr;
    logic [7:0]         item_data;
    logic [IW-1:0]      item_idx;
    logic               item_sdram, item_prom, serve, flush_req;

    jtpopeye_dwnld_skid #(.AW(AW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (skid_push),
        .pop       (skid_pop),
        .push_addr (ioctl_addr),
        .push_data (ioctl_data),
        .valid     (skid_valid),
        .addr      (skid_addr),
        .data      (skid_data),
        .overflow  (skid_ovf)
    );

    // Pick the item to serve (skid first) and decode its destination
    always_comb begin
        strobe        = downloading & ioctl_wr;
        item_addr     = skid_valid ? skid_addr : ioctl_addr;
        item_data     = skid_valid ? skid_data : ioctl_data;
        item_idx      = IW'((item_addr - PROM_START) >> PROM_AW);
        item_sdram    = item_addr < PROM_START;
        item_prom     = !item_sdram && (item_idx < IW'(NPROM));
        serve         = (state_q == ST_IDLE) && (skid_valid || strobe);
        skid_pop      = (state_q == ST_IDLE) && skid_valid;
        skid_push     = strobe && ((state_q != ST_IDLE) || skid_valid);
        skid_valid_nx = skid_push || (skid_valid && !skid_pop);
        // Pending end-of-download: latched fall, or the fall happening now
        flush_req     = !downloading && (flush_pend_q || downloading_q);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (serve && item_sdram)     state_d = ST_SDRAM;
                else if (serve && item_prom) state_d = ST_PROM;
            end
            ST_SDRAM: if (prog_rdy) state_d = ST_IDLE;
            ST_PROM:  state_d = ST_IDLE;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Work fully drained with the download over: spend one cycle in FLUSH for the pulse
        if (flush_req && (state_d == ST_IDLE) && !skid_valid_nx) state_d = ST_FLUSH;
    end

    // Output logic
    always_comb begin
        prog_addr_d  = prog_addr_q;
        prog_data_d  = prog_data_q;
        prog_mask_d  = prog_mask_q;
        prog_we_d    = prog_we_q;
        prom_addr_d  = prom_addr_q;
        prom_data_d  = prom_data_q;
        prom_we_d    = '0;
        if (serve && item_sdram) begin
            prog_we_d   = 1'b1;
            prog_addr_d = item_addr >> 1;
            prog_data_d = item_data;
            prog_mask_d = item_addr[0] ? MASK_HI : MASK_LO;
        end
        if ((state_q == ST_SDRAM) && prog_rdy) prog_we_d = 1'b0;
        if (serve && item_prom) begin
            prom_we_d   = NPROM'(1) << item_idx;
            prom_addr_d = item_addr[PROM_AW-1:0];
            prom_data_d = item_data;
        end
        dwnld_done_d = (state_d == ST_FLUSH);
        flush_pend_d = flush_req && (state_d != ST_FLUSH);
        busy_d       = (state_d != ST_IDLE) || skid_valid_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prog_addr_q   <= '0;
            prog_data_q   <= '0;
            prog_mask_q   <= MASK_NONE;
            prog_we_q     <= 1'b0;
            prom_addr_q   <= '0;
            prom_data_q   <= '0;
            prom_we_q     <= '0;
            busy_q        <= 1'b0;
            dwnld_done_q  <= 1'b0;
            flush_pend_q  <= 1'b0;
            downloading_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_addr_q   <= prog_addr_d;
            prog_data_q   <= prog_data_d;
            prog_mask_q   <= prog_mask_d;
            prog_we_q     <= prog_we_d;
            prom_addr_q   <= prom_addr_d;
            prom_data_q   <= prom_data_d;
            prom_we_q     <= prom_we_d;
            busy_q        <= busy_d;
            dwnld_done_q  <= dwnld_done_d;
            flush_pend_q  <= flush_pend_d;
            downloading_q <= downloading;
        end
    end

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_we    = prog_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_data  = prom_data_q;
    assign prom_we    = prom_we_q;
    assign busy       = busy_q;
    assign dwnld_done = dwnld_done_q;
    assign overflow   = skid_ovf;

endmodule
